// File: rtl/scaler_pkg.sv
// rtl/scaler_pkg.sv - shared codes for the scaler controller and the display decoder
package scaler_pkg;

    typedef enum logic [1:0] {
        NN = 2'd0,
        PR = 2'd1,
        DC = 2'd2,
        BA = 2'd3
    } algorithm_e;

    typedef enum logic [1:0] {
        Z1X = 2'd0,
        Z2X = 2'd1,
        Z4X = 2'd2,
        Z8X = 2'd3
    } zoom_e;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_e;

endpackage

// File: rtl/scaler_ctrl_if.sv
// rtl/scaler_ctrl_if.sv - controller to scaling-engine job handshake
interface scaler_ctrl_if;
    logic       ENGINE_START;
    logic       ENGINE_DONE;
    logic [1:0] ALGORITHM;
    logic [1:0] ZOOM_LEVEL;

    modport master (output ENGINE_START, ALGORITHM, ZOOM_LEVEL, input ENGINE_DONE);
    modport slave  (input ENGINE_START, ALGORITHM, ZOOM_LEVEL, output ENGINE_DONE);
endinterface

// File: rtl/scaler_ctrl_key_debounce.sv
// rtl/scaler_ctrl_key_debounce.sv - key synchroniser, stability filter under SCALER_CTRL_DEBOUNCE_EN
module key_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic key_n_i,
    output logic level_o
);

    // Reset to the pressed level so a key held through reset never looks like a new press.
    logic [1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], key_n_i};
        end
    end

`ifdef SCALER_CTRL_DEBOUNCE_EN
    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          stable_q, stable_d;

    always_comb begin
        cnt_d    = '0;
        stable_d = stable_q;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
                stable_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q    <= '0;
            stable_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            stable_q <= stable_d;
        end
    end

    assign level_o = ~stable_q;
`else
    assign level_o = ~sync_q[1];
`endif

endmodule

// File: rtl/scaler_ctrl.sv
// rtl/scaler_ctrl.sv - zoom/algorithm job controller; key filtering selected by SCALER_CTRL_DEBOUNCE_EN
module scaler_ctrl
    import scaler_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1000000,
    parameter int unsigned TIMEOUT_CYCLES  = 50000000
) (
    input  logic                 CLOCK_50,
    input  logic                 RESET,
    input  logic                 KEY_ZOOM_IN,
    input  logic                 KEY_ZOOM_OUT,
    input  logic [1:0]           SW_ALGORITHM,
    scaler_ctrl_if.master        eng,
    output logic                 BUSY,
    output logic                 ERROR
);

    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    state_e          state_q, state_d;
    logic [1:0]      alg_q, alg_d;
    logic [1:0]      zoom_q, zoom_d;
    logic            err_q, err_d;
    logic [1:0]      pend_q, pend_d;
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [1:0]      sw_meta_q, sw_sync_q;
    logic [1:0]      key_prev_q;
    logic [1:0]      key_lvl;
    logic [1:0]      press;
    logic            go_in, go_out, zoom_up, zoom_dn, alg_chg;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_in (
        .clk_i   (CLOCK_50),
        .rst_i   (RESET),
        .key_n_i (KEY_ZOOM_IN),
        .level_o (key_lvl[1])
    );

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_out (
        .clk_i   (CLOCK_50),
        .rst_i   (RESET),
        .key_n_i (KEY_ZOOM_OUT),
        .level_o (key_lvl[0])
    );

    // Bit 1 is zoom-in, bit 0 zoom-out, both in press and in the pending slot.
    assign press = key_lvl & ~key_prev_q;

    always_comb begin
        state_d = state_q;
        alg_d   = alg_q;
        zoom_d  = zoom_q;
        err_d   = err_q;
        pend_d  = pend_q;
        tmo_d   = tmo_q;
        go_in   = press[1] | pend_q[1];
        go_out  = press[0] | pend_q[0];
        zoom_up = go_in & ~go_out & (zoom_q != Z8X);
        zoom_dn = go_out & ~go_in & (zoom_q != Z1X);
        alg_chg = (sw_sync_q != alg_q);

        unique case (state_q)
            IDLE: begin
                pend_d = '0;
                tmo_d  = '0;
                if (zoom_up || zoom_dn || alg_chg) begin
                    alg_d   = sw_sync_q;
                    state_d = START;
                    if (zoom_up) begin
                        zoom_d = zoom_q + 2'd1;
                    end else if (zoom_dn) begin
                        zoom_d = zoom_q - 2'd1;
                    end
                end
            end
            START: begin
                tmo_d   = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Done has priority over a timeout expiring in the same cycle.
                if (eng.ENGINE_DONE) begin
                    err_d   = 1'b0;
                    state_d = IDLE;
                end else if (tmo_q == TW'(TIMEOUT_CYCLES - 1)) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase

        if (state_q != IDLE && pend_q == 2'b00) begin
            pend_d = press;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q    <= IDLE;
            alg_q      <= NN;
            zoom_q     <= Z1X;
            err_q      <= 1'b0;
            pend_q     <= '0;
            tmo_q      <= '0;
            sw_meta_q  <= '0;
            sw_sync_q  <= '0;
            key_prev_q <= 2'b11;
        end else begin
            state_q    <= state_d;
            alg_q      <= alg_d;
            zoom_q     <= zoom_d;
            err_q      <= err_d;
            pend_q     <= pend_d;
            tmo_q      <= tmo_d;
            sw_meta_q  <= SW_ALGORITHM;
            sw_sync_q  <= sw_meta_q;
            key_prev_q <= key_lvl;
        end
    end

    assign eng.ENGINE_START = (state_q == START);
    assign eng.ALGORITHM    = alg_q;
    assign eng.ZOOM_LEVEL   = zoom_q;
    assign BUSY             = (state_q != IDLE);
    assign ERROR            = err_q;

endmodule

// File: tb/tb_scaler_ctrl.sv
// tb/tb_scaler_ctrl.sv - directed table and sequence bench for scaler_ctrl
module tb_scaler_ctrl;

    typedef enum int {OP_IN, OP_OUT, OP_BOTH, OP_DONE, OP_IDLE} op_e;

    typedef struct {
        op_e        op;
        logic [1:0] sw;
        int         n;
        int         ds;
        logic [1:0] z;
        logic [1:0] a;
        logic       b;
        logic       e;
    } vec_t;

`ifdef SCALER_CTRL_DEBOUNCE_EN
    localparam int HOLD   = 6;
    localparam int SW_LAG = 4;
`else
    localparam int HOLD   = 3;
    localparam int SW_LAG = 0;
`endif

    logic       clk;
    logic       rst;
    logic       key_in;
    logic       key_out;
    logic [1:0] sw;
    logic       busy;
    logic       err;
    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_start  = 0;
    vec_t       tbl[17];

    scaler_ctrl_if eng();

    scaler_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(16)) dut (
        .CLOCK_50     (clk),
        .RESET        (rst),
        .KEY_ZOOM_IN  (key_in),
        .KEY_ZOOM_OUT (key_out),
        .SW_ALGORITHM (sw),
        .eng          (eng),
        .BUSY         (busy),
        .ERROR        (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (eng.ENGINE_START === 1'b1) n_start++;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not reach its summary");
        $fatal(1, "watchdog expired");
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic expect_state(input string tag, input int s0, input int ds,
                                input logic [1:0] z, input logic [1:0] a,
                                input logic b, input logic e);
        check({tag, " starts"}, n_start - s0, ds);
        check({tag, " zoom"}, eng.ZOOM_LEVEL, z);
        check({tag, " alg"}, eng.ALGORITHM, a);
        check({tag, " busy"}, busy, b);
        check({tag, " error"}, err, e);
    endtask

    task automatic press(input logic [1:0] m);
        if (m[1]) key_in = 1'b0;
        if (m[0]) key_out = 1'b0;
        cyc(HOLD);
        key_in  = 1'b1;
        key_out = 1'b1;
        cyc(HOLD);
    endtask

    task automatic pulse_done();
        eng.ENGINE_DONE = 1'b1;
        cyc(1);
        eng.ENGINE_DONE = 1'b0;
        cyc(2);
    endtask

    function automatic vec_t mk(op_e op, logic [1:0] s, int n, int ds,
                                logic [1:0] z, logic [1:0] a, logic b, logic e);
        vec_t v;
        v.op = op; v.sw = s; v.n = n; v.ds = ds;
        v.z = z; v.a = a; v.b = b; v.e = e;
        return v;
    endfunction

    initial begin
        int  s0;
        int  s1;
        bit  seen;

        tbl[0]  = mk(OP_OUT,  2'd0, 0,  0, 2'd0, 2'd0, 1'b0, 1'b0);
        tbl[1]  = mk(OP_IN,   2'd0, 0,  1, 2'd1, 2'd0, 1'b1, 1'b0);
        tbl[2]  = mk(OP_DONE, 2'd0, 0,  0, 2'd1, 2'd0, 1'b0, 1'b0);
        tbl[3]  = mk(OP_IN,   2'd0, 0,  1, 2'd2, 2'd0, 1'b1, 1'b0);
        tbl[4]  = mk(OP_DONE, 2'd0, 0,  0, 2'd2, 2'd0, 1'b0, 1'b0);
        tbl[5]  = mk(OP_BOTH, 2'd0, 0,  0, 2'd2, 2'd0, 1'b0, 1'b0);
        tbl[6]  = mk(OP_IN,   2'd0, 0,  1, 2'd3, 2'd0, 1'b1, 1'b0);
        tbl[7]  = mk(OP_DONE, 2'd0, 0,  0, 2'd3, 2'd0, 1'b0, 1'b0);
        tbl[8]  = mk(OP_IN,   2'd0, 0,  0, 2'd3, 2'd0, 1'b0, 1'b0);
        tbl[9]  = mk(OP_OUT,  2'd0, 0,  1, 2'd2, 2'd0, 1'b1, 1'b0);
        tbl[10] = mk(OP_DONE, 2'd0, 0,  0, 2'd2, 2'd0, 1'b0, 1'b0);
        tbl[11] = mk(OP_IDLE, 2'd1, 6,  1, 2'd2, 2'd1, 1'b1, 1'b0);
        tbl[12] = mk(OP_DONE, 2'd1, 0,  0, 2'd2, 2'd1, 1'b0, 1'b0);
        tbl[13] = mk(OP_IDLE, 2'd3, 6,  1, 2'd2, 2'd3, 1'b1, 1'b0);
        tbl[14] = mk(OP_IDLE, 2'd3, 20, 0, 2'd2, 2'd3, 1'b0, 1'b1);
        tbl[15] = mk(OP_OUT,  2'd3, 0,  1, 2'd1, 2'd3, 1'b1, 1'b1);
        tbl[16] = mk(OP_DONE, 2'd3, 0,  0, 2'd1, 2'd3, 1'b0, 1'b0);

        rst = 1'b1; key_in = 1'b1; key_out = 1'b1; sw = 2'd0;
        eng.ENGINE_DONE = 1'b0;
        cyc(3);
        expect_state("reset", n_start, 0, 2'd0, 2'd0, 1'b0, 1'b0);
        check("reset start", eng.ENGINE_START, 1'b0);
        rst = 1'b0;
        cyc(10);

        for (int i = 0; i < 17; i++) begin
            s0 = n_start;
            sw = tbl[i].sw;
            case (tbl[i].op)
                OP_IN:   press(2'b10);
                OP_OUT:  press(2'b01);
                OP_BOTH: press(2'b11);
                OP_DONE: pulse_done();
                default: cyc(tbl[i].n);
            endcase
            expect_state($sformatf("row%0d", i), s0, tbl[i].ds, tbl[i].z, tbl[i].a, tbl[i].b, tbl[i].e);
        end

        // Two zoom-in presses while a job at 2x runs collapse into one follow-up job.
        s0 = n_start;
        sw = 2'd0;
        cyc(6);
`ifndef SCALER_CTRL_DEBOUNCE_EN
        expect_state("pend job", s0, 1, 2'd1, 2'd0, 1'b1, 1'b0);
        s1 = n_start;
        press(2'b10);
        press(2'b10);
        expect_state("pend busy", s1, 0, 2'd1, 2'd0, 1'b1, 1'b0);
        pulse_done();
        expect_state("pend replay", s1, 1, 2'd2, 2'd0, 1'b1, 1'b0);
        pulse_done();
        expect_state("pend end", s1, 1, 2'd2, 2'd0, 1'b0, 1'b0);
`else
        pulse_done();
        press(2'b10);
        pulse_done();
        expect_state("pre combo", s0, 2, 2'd2, 2'd0, 1'b0, 1'b0);
`endif

        // Algorithm change and zoom-in land in the same IDLE cycle.
        s0 = n_start;
        key_in = 1'b0;
        if (SW_LAG > 0) cyc(SW_LAG);
        sw = 2'd2;
        cyc(HOLD - SW_LAG);
        key_in = 1'b1;
        cyc(HOLD);
        expect_state("combo", s0, 1, 2'd3, 2'd2, 1'b1, 1'b0);
        pulse_done();

        // Done on the last timeout cycle wins.
        key_out = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            cyc(1);
            if (eng.ENGINE_START === 1'b1) seen = 1'b1;
        end
        check("expiry start seen", seen, 1'b1);
        key_out = 1'b1;
        cyc(15);
        check("expiry busy before", busy, 1'b1);
        eng.ENGINE_DONE = 1'b1;
        cyc(1);
        eng.ENGINE_DONE = 1'b0;
        check("expiry busy after", busy, 1'b0);
        check("expiry error", err, 1'b0);
        check("expiry zoom", eng.ZOOM_LEVEL, 2'd2);

        // Reset mid-job with zoom-in held through reset release.
        press(2'b10);
        key_in = 1'b0;
        s0 = n_start;
        rst = 1'b1;
        cyc(3);
        expect_state("mid reset", s0, 0, 2'd0, 2'd0, 1'b0, 1'b0);
        rst = 1'b0;
        cyc(6);
        expect_state("post reset", s0, 1, 2'd0, 2'd2, 1'b1, 1'b0);
        pulse_done();
        s0 = n_start;
        cyc(10);
        expect_state("held key", s0, 0, 2'd0, 2'd2, 1'b0, 1'b0);
        key_in = 1'b1;
        cyc(HOLD + 4);
        press(2'b10);
        expect_state("repress", s0, 1, 2'd1, 2'd2, 1'b1, 1'b0);
        pulse_done();

`ifdef SCALER_CTRL_DEBOUNCE_EN
        s0 = n_start;
        key_in = 1'b0;
        cyc(3);
        key_in = 1'b1;
        cyc(10);
        expect_state("glitch", s0, 0, 2'd1, 2'd2, 1'b0, 1'b0);
        key_in = 1'b0;
        cyc(5);
        key_in = 1'b1;
        cyc(8);
        expect_state("debounced", s0, 1, 2'd2, 2'd2, 1'b1, 1'b0);
        pulse_done();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
